// File: rtl/four_way_mux_arbiter_if.sv
// four_way_mux_arbiter_if: request/grant bus between the requesters and the mux arbiter
interface four_way_mux_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] op;
  logic       bus_valid;
  logic       switch;
  modport master(output req, input gnt, op, bus_valid, switch);
  modport slave(input req, output gnt, op, bus_valid, switch);
endinterface

// File: rtl/four_way_mux_arbiter.sv
// four_way_mux_arbiter: round-robin owner of a 16-bit four-way mux with bounded hold time
module four_way_mux_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  four_way_mux_arbiter_if.slave bus
);
  typedef enum logic {IDLE, OWN} state_t;
  localparam logic [CNT_W-1:0] TOP = CNT_W'(MAX_HOLD - 1);
  state_t           state, state_n;
  logic [1:0]       last, last_n, op_n, ptr, win;
  logic [3:0]       gnt_n, mask, others;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             valid_n, sw_n, found, take;
  assign others = bus.req & ~bus.gnt;
  assign ptr    = state == IDLE ? last : bus.op;
  assign mask   = state == IDLE ? bus.req : others;
  // One search serves every grant path: from last when idle, from the owner (excluded) when owning
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int k = 1; k <= 4; k++)
      if (!found && mask[2'(int'(ptr) + k)]) begin
        found = 1'b1;
        win   = 2'(int'(ptr) + k);
      end
  end
  always_comb begin
    state_n = state;
    last_n  = last;
    cnt_n   = cnt;
    gnt_n   = bus.gnt;
    op_n    = bus.op;
    valid_n = bus.bus_valid;
    sw_n    = 1'b0;
    take    = state == IDLE ? found : found && (!bus.req[bus.op] || cnt == TOP);
    if (take) begin
      state_n = OWN;
      gnt_n   = 4'b0001 << win;
      op_n    = win;
      last_n  = win;
      valid_n = 1'b1;
      sw_n    = 1'b1;
      cnt_n   = '0;
    end else if (state == OWN && !bus.req[bus.op]) begin
      state_n = IDLE;
      gnt_n   = 4'b0000;
      valid_n = 1'b0;
    end else if (state == OWN) begin
      cnt_n = cnt == TOP ? cnt : cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state         <= IDLE;
      last          <= 2'd3;
      cnt           <= '0;
      bus.gnt       <= 4'b0000;
      bus.op        <= 2'd0;
      bus.bus_valid <= 1'b0;
      bus.switch    <= 1'b0;
    end else begin
      state         <= state_n;
      last          <= last_n;
      cnt           <= cnt_n;
      bus.gnt       <= gnt_n;
      bus.op        <= op_n;
      bus.bus_valid <= valid_n;
      bus.switch    <= sw_n;
    end
endmodule

// File: tb/tb_four_way_mux_arbiter.sv
// tb_four_way_mux_arbiter: directed and random checks against a tenure-based reference model
module tb_four_way_mux_arbiter;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  four_way_mux_arbiter_if bus();
  four_way_mux_arbiter #(.MAX_HOLD(MH), .CNT_W(3)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int own, last_w, tenure, m_op;
  logic m_sw;
  int wait_c[4];
  int max_wait = 0;
  bit track = 0;
  int sw_cnt;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int search(int p, logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  task automatic model_reset();
    own = -1; last_w = 3; tenure = 0; m_op = 0; m_sw = 0;
  endtask
  // tenure = cycles the current owner has held the bus; it may rotate once tenure reaches MH
  task automatic model_edge(logic [3:0] r);
    int w;
    m_sw = 0;
    if (own < 0) w = search(last_w, r);
    else if (!r[own] || tenure >= MH) w = search(own, r & ~(4'b0001 << own));
    else w = -1;
    if (w >= 0) begin
      own = w; last_w = w; m_op = w; tenure = 1; m_sw = 1;
    end else if (own >= 0 && !r[own]) own = -1;
    else if (own >= 0) tenure++;
  endtask
  task automatic step(logic [3:0] r);
    bus.req = r;
    @(posedge clk);
    if (reset) model_edge(r);
    #1;
    check("gnt", 32'(bus.gnt), own < 0 ? 0 : (1 << own));
    check("op", 32'(bus.op), m_op);
    check("bus_valid", 32'(bus.bus_valid), own >= 0 ? 1 : 0);
    check("switch", 32'(bus.switch), 32'(m_sw));
    if (track)
      for (int i = 0; i < 4; i++) begin
        wait_c[i] = (r[i] && !bus.gnt[i]) ? wait_c[i] + 1 : 0;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
  endtask
  initial begin
    logic [3:0] r;
    model_reset();
    bus.req = 4'b1111;
    repeat (50) step(4'b1111);
    reset = 1'b1;
    step(4'b1111);
    check("rel_gnt", 32'(bus.gnt), 32'h1);
    check("rel_switch", 32'(bus.switch), 32'h1);
    step(4'b0000);
    step(4'b0100);
    check("solo_gnt", 32'(bus.gnt), 32'h4);
    check("solo_op", 32'(bus.op), 32'h2);
    sw_cnt = 32'(bus.switch);
    repeat (9) begin
      step(4'b0100);
      sw_cnt += 32'(bus.switch);
    end
    check("solo_sw_once", sw_cnt, 1);
    step(4'b0000);
    check("drop_gnt", 32'(bus.gnt), 32'h0);
    check("drop_op", 32'(bus.op), 32'h2);
    repeat (24) step(4'b1111);
    step(4'b0000);
    step(4'b0010);
    repeat (2) step(4'b0010);
    step(4'b1001);
    check("handoff_gnt", 32'(bus.gnt), 32'h8);
    check("handoff_op", 32'(bus.op), 32'h3);
    check("handoff_valid", 32'(bus.bus_valid), 32'h1);
    step(4'b0000);
    repeat (6) step(4'b0100);
    step(4'b0101);
    check("sat_rot_gnt", 32'(bus.gnt), 32'h1);
    #2 reset = 1'b0;
    model_reset();
    #2 reset = 1'b1;
    step(4'b1000);
    check("pre_async_gnt", 32'(bus.gnt), 32'h8);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("async_gnt", 32'(bus.gnt), 32'h0);
    check("async_valid", 32'(bus.bus_valid), 32'h0);
    #1 reset = 1'b1;
    step(4'b1000);
    check("post_async_gnt", 32'(bus.gnt), 32'h8);
    check("post_async_op", 32'(bus.op), 32'h3);
    track = 1;
    for (int i = 0; i < 4; i++) wait_c[i] = 0;
    r = 4'b0000;
    repeat (3000) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(3) == 0) r[i] = ~r[i];
      step(r);
    end
    check("starve_bound", 32'(max_wait <= 3 * MH + 1), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
